// File: rtl/axi_stream_downsizer.sv
// Wide-to-narrow AXI-Stream converter: slice 0 appears one cycle after a word is accepted.
// Backpressure: holds one word; s_axis_tready drops while draining and reopens on the last slice's output fire.
module axi_stream_downsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int BDIM      = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int BLK_W = (BDIM > 1) ? $clog2(BDIM) : 1;

  typedef enum logic {EMPTY = 1'b0, DRAIN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [IN_WIDTH-1:0] hold, hold_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [BLK_W-1:0]    blk, blk_nxt;
  logic                full;
  logic                out_fire;
  logic                in_fire;
  logic                last_slice;

  assign full       = (state == DRAIN);
  assign last_slice = (idx == IDX_W'(RATIO - 1));
  assign out_fire   = full && m_axis_tready;
  // Combinational through m_axis_tready so the next word loads on the last slice's edge.
  assign s_axis_tready = !full || (out_fire && last_slice);
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = full;
  assign m_axis_tlast  = full && (blk == BLK_W'(BDIM - 1));

  always_comb begin
    m_axis_tdata = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) m_axis_tdata = hold[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    idx_nxt   = idx;
    blk_nxt   = blk;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          hold_nxt  = s_axis_tdata;
          idx_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (!last_slice) begin
            idx_nxt = idx + IDX_W'(1);
          end else if (in_fire) begin
            hold_nxt = s_axis_tdata;
            idx_nxt  = '0;
          end else begin
            idx_nxt   = '0;
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Block framing counts output beats only, so a block may end mid-word.
    if (out_fire) begin
      blk_nxt = (blk == BLK_W'(BDIM - 1)) ? '0 : blk + BLK_W'(1);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= EMPTY;
      hold  <= '0;
      idx   <= '0;
      blk   <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      idx   <= idx_nxt;
      blk   <= blk_nxt;
    end
  end

endmodule

// File: tb/tb_axi_stream_downsizer.sv
// Bench for axi_stream_downsizer: three configurations (ratio 2/1/4) checked every cycle
// against a queue-of-beats model, plus directed literal checks on the ratio-2 instance.
module tb_axi_stream_downsizer;

  logic        clk;
  logic        rst_n;
  logic        armed;
  logic [31:0] s_dat [3];
  logic        s_vld [3];
  logic        s_rdy [3];
  logic [31:0] m_dat [3];
  logic        m_vld [3];
  logic        m_rdy [3];
  logic        m_lst [3];
  logic        fired [3];
  logic [15:0] md0;
  logic [31:0] md1;
  logic [7:0]  md2;

  int vectors;
  int miscompares;
  int cycle;
  int rdy_low;
  logic [31:0] log_d[$];
  logic        log_l[$];
  int          log_c[$];

  always_comb begin
    m_dat[0] = {16'h0, md0};
    m_dat[1] = md1;
    m_dat[2] = {24'h0, md2};
  end

  axi_stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(16), .BDIM(3)) u_r2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tdata(s_dat[0]), .s_axis_tvalid(s_vld[0]), .s_axis_tready(s_rdy[0]),
    .m_axis_tdata(md0), .m_axis_tvalid(m_vld[0]), .m_axis_tready(m_rdy[0]),
    .m_axis_tlast(m_lst[0]));

  axi_stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(32), .BDIM(5)) u_r1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tdata(s_dat[1]), .s_axis_tvalid(s_vld[1]), .s_axis_tready(s_rdy[1]),
    .m_axis_tdata(md1), .m_axis_tvalid(m_vld[1]), .m_axis_tready(m_rdy[1]),
    .m_axis_tlast(m_lst[1]));

  axi_stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .BDIM(8)) u_r4 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_tdata(s_dat[2]), .s_axis_tvalid(s_vld[2]), .s_axis_tready(s_rdy[2]),
    .m_axis_tdata(md2), .m_axis_tvalid(m_vld[2]), .m_axis_tready(m_rdy[2]),
    .m_axis_tlast(m_lst[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cycle = 0;
    forever begin
      @(posedge clk);
      cycle = cycle + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: every accepted word becomes RATIO queued beats; tlast from the beat count since reset.
  for (genvar k = 0; k < 3; k++) begin : g_model
    localparam int R  = (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    localparam int OW = 32 / R;
    localparam int BD = (k == 0) ? 3 : ((k == 1) ? 5 : 8);
    localparam logic [31:0] MASK = 32'((64'd1 << OW) - 64'd1);
    logic [32:0] q[$];
    int nbeat;
    initial begin
      nbeat = 0;
      forever begin
        @(negedge clk);
        if (armed) begin
          if (!rst_n) begin
            q.delete();
            nbeat = 0;
          end else begin
            chk($sformatf("tvalid_%0d", k), m_vld[k], q.size() != 0);
            chk($sformatf("tready_%0d", k), s_rdy[k],
                (q.size() == 0) || (q.size() == 1 && m_rdy[k]));
            if (q.size() != 0) begin
              chk($sformatf("tdata_%0d", k), m_dat[k], q[0][31:0]);
              chk($sformatf("tlast_%0d", k), m_lst[k], q[0][32]);
            end
            if (m_vld[k] && m_rdy[k] && q.size() != 0) void'(q.pop_front());
            if (s_vld[k] && s_rdy[k]) begin
              for (int j = 0; j < R; j++) begin
                q.push_back({(nbeat % BD) == BD - 1, (s_dat[k] >> (j * OW)) & MASK});
                nbeat = nbeat + 1;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (armed && rst_n) begin
        if (!s_rdy[0]) rdy_low = rdy_low + 1;
        if (m_vld[0] && m_rdy[0]) begin
          log_d.push_back(m_dat[0]);
          log_l.push_back(m_lst[0]);
          log_c.push_back(cycle);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_c.delete();
    rdy_low = 0;
  endtask

  // Leaves tvalid high so consecutive calls stream back to back.
  task automatic send(input int k, input logic [31:0] d);
    logic f;
    int   n;
    s_vld[k] = 1'b1;
    s_dat[k] = d;
    n = 0;
    f = 1'b0;
    while (!f && n < 200) begin
      @(negedge clk);
      f = s_rdy[k];
      cyc();
      n = n + 1;
    end
    if (!f) chk("send_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int gaps;
    int words1;
    int n;
    vectors     = 0;
    miscompares = 0;
    rdy_low     = 0;
    armed       = 1'b0;
    rst_n       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_vld[k] = 1'b0;
      s_dat[k] = '0;
      m_rdy[k] = 1'b1;
      fired[k] = 1'b0;
    end
    cyc();
    cyc();
    armed = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tvalid_%0d", k), m_vld[k], 0);
      chk($sformatf("rst_tlast_%0d", k), m_lst[k], 0);
      chk($sformatf("rst_tdata_%0d", k), m_dat[k], 0);
      chk($sformatf("rst_tready_%0d", k), s_rdy[k], 1);
    end
    cyc();

    // Basic split
    clear_log();
    send(0, 32'hAABBCCDD);
    s_vld[0] = 1'b0;
    repeat (4) cyc();
    chk("basic_count", log_d.size(), 2);
    chk("basic_beat0", log_d[0], 32'hCCDD);
    chk("basic_beat1", log_d[1], 32'hAABB);
    chk("basic_consecutive", log_c[1] - log_c[0], 1);
    chk("basic_tready_low", rdy_low, 1);

    // Streaming, 8 back-to-back words
    clear_log();
    for (int i = 0; i < 8; i++) send(0, 32'h00010000 + 32'(i));
    s_vld[0] = 1'b0;
    repeat (4) cyc();
    chk("stream_count", log_d.size(), 16);
    gaps = 0;
    for (int b = 1; b < log_c.size(); b++) if (log_c[b] - log_c[b-1] != 1) gaps = gaps + 1;
    chk("stream_gaps", gaps, 0);
    for (int b = 0; b < 16; b++)
      chk($sformatf("stream_beat%0d", b), log_d[b], (b % 2 == 0) ? 32'(b / 2) : 32'h0001);

    // Backpressure with a second word waiting
    m_rdy[0] = 1'b0;
    send(0, 32'h12345678);
    s_dat[0] = 32'h9ABCDEF0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_data", m_dat[0], 32'h5678);
      chk("bp_no_early_accept", s_rdy[0], 0);
      cyc();
    end
    clear_log();
    m_rdy[0] = 1'b1;
    send(0, 32'h9ABCDEF0);
    s_vld[0] = 1'b0;
    repeat (4) cyc();
    chk("bp_count", log_d.size(), 4);
    chk("bp_beat0", log_d[0], 32'h5678);
    chk("bp_beat1", log_d[1], 32'h1234);
    chk("bp_beat2", log_d[2], 32'hDEF0);
    chk("bp_beat3", log_d[3], 32'h9ABC);

    // Framing, BDIM=3
    pulse_reset();
    clear_log();
    send(0, 32'h11110000);
    send(0, 32'h33332222);
    send(0, 32'h55554444);
    s_vld[0] = 1'b0;
    repeat (4) cyc();
    chk("frame_count", log_d.size(), 6);
    for (int b = 0; b < 6; b++)
      chk($sformatf("frame_tlast%0d", b), log_l[b], (b == 2) || (b == 5));
    chk("frame_beat3_data", log_d[2], 32'h2222);

    // Reset mid-drain
    clear_log();
    send(0, 32'hDEADBEEF);
    s_vld[0] = 1'b0;
    cyc();
    pulse_reset();
    send(0, 32'h0000FFFF);
    send(0, 32'h77776666);
    s_vld[0] = 1'b0;
    repeat (4) cyc();
    chk("rstmid_count", log_d.size(), 5);
    chk("rstmid_beat0", log_d[0], 32'hBEEF);
    chk("rstmid_beat1", log_d[1], 32'hFFFF);
    chk("rstmid_beat2", log_d[2], 32'h0000);
    chk("rstmid_tlast1", log_l[1], 0);
    chk("rstmid_tlast2", log_l[2], 0);
    chk("rstmid_tlast3", log_l[3], 1);

    // Random valid/ready on all instances until the ratio-1 instance has taken 200 words
    words1 = 0;
    n = 0;
    while (words1 < 200 && n < 6000) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) fired[k] = s_vld[k] && s_rdy[k];
      if (fired[1]) words1 = words1 + 1;
      cyc();
      for (int k = 0; k < 3; k++) begin
        if (!s_vld[k] || fired[k]) begin
          s_vld[k] = ($urandom % 3) != 0;
          s_dat[k] = $urandom;
        end
        m_rdy[k] = ($urandom % 4) != 0;
      end
      n = n + 1;
    end
    chk("random_words_ratio1", words1 >= 200, 1);

    // Both sides always ready
    for (int k = 0; k < 3; k++) m_rdy[k] = 1'b1;
    for (int k = 0; k < 3; k++) s_vld[k] = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) fired[k] = s_vld[k] && s_rdy[k];
      if (fired[1]) n = n + 1;
      cyc();
      for (int k = 0; k < 3; k++) if (fired[k]) s_dat[k] = $urandom;
    end
    chk("ratio1_throughput", n, 20);

    for (int k = 0; k < 3; k++) s_vld[k] = 1'b0;
    repeat (12) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_stream_downsizer.md
# axi_stream_downsizer

Registered AXI-Stream width down-converter that sits directly downstream of the stream merge stage. It accepts wide IN_WIDTH words and emits them as IN_WIDTH/OUT_WIDTH narrow beats, least-significant slice first. It also marks the last narrow beat of every BDIM-beat block with TLAST, so consumers receive block-framed narrow traffic.

## Interface
- IN_WIDTH, 32, input word width in bits; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 16, output beat width in bits; must be ≥1.
- BDIM, 32, output beats per block; must be ≥1. TLAST marks beat BDIM-1 of each block.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH, narrow beats per wide word.
- ap_clk  input  1  sole clock; all logic on rising edge.
- ap_rst_n  input  1  reset, synchronous, active-low.
- s_axis_tdata  input  IN_WIDTH  wide input payload.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready.
- m_axis_tdata  output  OUT_WIDTH  narrow output payload.
- m_axis_tvalid  output  1  output valid.
- m_axis_tready  input  1  output backpressure.
- m_axis_tlast  output  1  high on the final beat of each BDIM-beat block.

## Operation
- State:
  - `hold` is an IN_WIDTH register.
  - `full` is a flag.
  - `idx` is a slice index, 0..RATIO-1.
  - `blk` is a beat counter, 0..BDIM-1.
- States:
  - EMPTY (`full`=0).
  - DRAIN (`full`=1).
- Output beat fire = m_axis_tvalid && m_axis_tready. Input fire = s_axis_tvalid && s_axis_tready.
- m_axis_tdata = `hold`[idx*OUT_WIDTH +: OUT_WIDTH].
- m_axis_tvalid = `full`.
- m_axis_tlast = `full` && (`blk` == BDIM-1).
- s_axis_tready = !`full` || (output fire && `idx` == RATIO-1). This is combinational from m_axis_tready and permits a zero-bubble refill.
- EMPTY:
  - On input fire: `hold` ← s_axis_tdata, `idx` ← 0, go to DRAIN.
- DRAIN, on output fire with `idx` < RATIO-1:
  - `idx` ← `idx`+1.
- DRAIN, on output fire with `idx` == RATIO-1:
  - If input fires in the same cycle: load a new word, `idx` ← 0, stay in DRAIN.
  - Otherwise: go to EMPTY.
- `blk` advances on every output fire and wraps from BDIM-1 to 0. It is independent of word boundaries, so a block may end mid-word.
- With no output fire, `hold`, `idx` and `blk` hold. m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid is high and m_axis_tready is low.
- RATIO==1 degenerates to a one-deep registered pipeline stage with full throughput.
- Input data is never dropped or duplicated. Each accepted word yields exactly RATIO output beats, in order.

## Timing
- Reset (ap_rst_n low at a rising edge):
  - `full`=0, `idx`=0, `blk`=0, `hold`=0.
  - Outputs: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=1 from the first cycle after reset.
- Reset mid-operation discards the held word and any partial block. The first beat after reset starts a new block at `blk`=0.
- Latency: a word accepted at edge N presents its first slice at m_axis_tdata from edge N+1.
- Throughput: one narrow beat per cycle under continuous valid/ready. Input accepts one word per RATIO cycles with no bubble between words.
- Simultaneous last-slice output fire and input fire produce a back-to-back transfer: the new word's slice 0 appears in the next cycle.
- s_axis_tready may drop only while `full` is high. An upstream stage holding tvalid sees its word accepted on the first cycle in which the tready equation is true.
- `blk` wrap and `idx` wrap coinciding, e.g. BDIM a multiple of RATIO: both reset to 0 on the same edge, and TLAST is asserted on that beat.

## Test plan
- Basic split, IN_WIDTH=32, OUT_WIDTH=16, m_axis_tready=1:
  - Stimulus: s_axis_tdata=0xAABBCCDD.
  - Required: m_axis_tdata=0xCCDD then 0xAABB on consecutive cycles, s_axis_tready low exactly one cycle.
- Streaming, ready held high:
  - Stimulus: 8 back-to-back words 0x00010000+i.
  - Required: 16 beats, no gaps in m_axis_tvalid; order 0x0000,0x0001,0x0001,0x0001,…
- Backpressure:
  - Stimulus: word 0x12345678, m_axis_tready low for 5 cycles after the first valid.
  - Required: m_axis_tdata stays 0x5678 for all 5 cycles, then 0x5678, 0x1234 drain; no second word accepted early.
- Framing, BDIM=3, RATIO=2:
  - Stimulus: 3 words.
  - Required: m_axis_tlast high on output beats 3 and 6 only; beat 3 is slice 0 of word 2.
- Reset mid-drain:
  - Stimulus: ap_rst_n low for 1 cycle after slice 0 of 0xDEADBEEF, then new word 0x0000FFFF.
  - Required: no 0xDEAD beat; outputs 0xFFFF, 0x0000; `blk` restarts at 0.
- RATIO=1 (OUT_WIDTH=32):
  - Stimulus: random valid/ready toggling over 200 words.
  - Required: output sequence equals input sequence, one-cycle latency, full throughput when both sides are always ready.
